// File: rtl/pll_div_pkg.sv
// Shared types and constants for the programmable PLL divider.
package pll_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_e;

    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/pll_div_counter.sv
// Period counter for the divider: holds N_cur, detects wrap, and registers Fout/Period_tick
// from the same next-count value so the outputs always line up with cnt.
module pll_div_counter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             advance_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             wrap_o,
    output logic             fout_o,
    output logic             tick_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ncur_q, ncur_d;
    logic [WIDTH-1:0] cnt_inc;
    logic             fout_q, fout_d;
    logic             tick_q, tick_d;

    assign cnt_inc = cnt_q + 1'b1;
    assign wrap_o  = (cnt_q == ncur_q - 1'b1);

    always_comb begin
        ncur_d = load_i ? load_val_i : ncur_q;
        cnt_d  = '0;
        fout_d = 1'b0;
        tick_d = 1'b0;
        if (start_i) begin
            fout_d = 1'b1;
            tick_d = 1'b1;
        end else if (advance_i) begin
            // A wrap starts a fresh period; phase 0 is always high since N_cur >= 2.
            if (wrap_o) begin
                fout_d = 1'b1;
                tick_d = 1'b1;
            end else begin
                cnt_d  = cnt_inc;
                fout_d = (cnt_inc < (ncur_q >> 1));
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            ncur_q <= WIDTH'(DEFAULT_DIV);
            fout_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ncur_q <= ncur_d;
            fout_q <= fout_d;
            tick_q <= tick_d;
        end
    end

    assign fout_o = fout_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/pll_div_ctrl.sv
// Glitch-free programmable divider Fout = Fin/N: run/stop sequencing FSM plus a
// one-deep ratio handshake whose value is applied only at period boundaries.
module pll_div_ctrl
    import pll_div_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             Fin,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] Div_in,
    input  logic             Div_valid,
    output logic             Div_ready,
    output logic             Fout,
    output logic             Period_tick,
    output logic             Active,
    output logic             Err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             err_q, err_d;
    logic             start, advance, load, wrap, xfer;

    assign xfer = Div_valid && !pend_vld_q;
    assign load = pend_vld_q && ((state_q == IDLE) || wrap);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (En) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                advance = 1'b1;
                if (!En) state_d = STOPPING;
            end
            STOPPING: begin
                // Halt only at the end of a complete period; re-enable resumes seamlessly.
                if (En) begin
                    state_d = RUN;
                    advance = 1'b1;
                end else if (wrap) begin
                    state_d = IDLE;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        err_d      = err_q;
        if (load) pend_vld_d = 1'b0;
        if (xfer) begin
            pend_vld_d = 1'b1;
            if (Div_in < WIDTH'(MIN_DIV)) begin
                pend_d = WIDTH'(MIN_DIV);
                err_d  = 1'b1;
            end else begin
                pend_d = Div_in;
            end
        end
    end

    always_ff @(posedge Fin or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
        end
    end

    pll_div_counter #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) u_counter (
        .clk_i     (Fin),
        .rst_i     (Reset),
        .start_i   (start),
        .advance_i (advance),
        .load_i    (load),
        .load_val_i(pend_q),
        .wrap_o    (wrap),
        .fout_o    (Fout),
        .tick_o    (Period_tick)
    );

    assign Div_ready = !pend_vld_q;
    assign Active    = (state_q != IDLE);
    assign Err       = err_q;

endmodule

// File: tb/tb_pll_div_ctrl.sv
// Directed bench for pll_div_ctrl: a phase/ratio model checked every cycle, plus literal waveform checks.
module tb_pll_div_ctrl;

    localparam int DEF = 2;

    logic       Fin       = 1'b0;
    logic       Reset     = 1'b0;
    logic       En        = 1'b0;
    logic [7:0] Div_in    = '0;
    logic       Div_valid = 1'b0;
    logic       Div_ready, Fout, Period_tick, Active, Err;

    int n_checks = 0;
    int n_fail   = 0;

    pll_div_ctrl #(
        .WIDTH      (8),
        .DEFAULT_DIV(DEF)
    ) dut (
        .Fin        (Fin),
        .Reset      (Reset),
        .En         (En),
        .Div_in     (Div_in),
        .Div_valid  (Div_valid),
        .Div_ready  (Div_ready),
        .Fout       (Fout),
        .Period_tick(Period_tick),
        .Active     (Active),
        .Err        (Err)
    );

    always #5 Fin = ~Fin;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: on/off, phase within the period, current ratio, queue of pending ratios.
    // The divider halts at a period end only if En was low in the previous cycle and is still low.
    int  m_n = DEF;
    int  m_ph = 0;
    bit  m_on = 1'b0;
    bit  m_err = 1'b0;
    bit  m_prev_en = 1'b0;
    bit  m_xfer;
    int  m_pq[$];

    always @(posedge Fin or posedge Reset) begin
        if (Reset) begin
            m_on = 1'b0; m_ph = 0; m_n = DEF; m_pq.delete(); m_err = 1'b0; m_prev_en = 1'b0;
        end else begin
            m_xfer = Div_valid && (m_pq.size() == 0);
            if (!m_on) begin
                if (m_pq.size() > 0) m_n = m_pq.pop_front();
                if (En) begin
                    m_on = 1'b1;
                    m_ph = 0;
                end
            end else if (m_ph == m_n - 1) begin
                m_ph = 0;
                if (m_pq.size() > 0) m_n = m_pq.pop_front();
                if (!En && !m_prev_en) m_on = 1'b0;
            end else begin
                m_ph++;
            end
            if (m_xfer) begin
                if (Div_in < 2) begin
                    m_pq.push_back(2);
                    m_err = 1'b1;
                end else begin
                    m_pq.push_back(int'(Div_in));
                end
            end
            m_prev_en = En;
        end
    end

    always @(negedge Fin) begin
        chk("Fout",        int'(Fout),        int'(m_on && (m_ph < m_n / 2)));
        chk("Period_tick", int'(Period_tick), int'(m_on && (m_ph == 0)));
        chk("Active",      int'(Active),      int'(m_on));
        chk("Div_ready",   int'(Div_ready),   int'(m_pq.size() == 0));
        chk("Err",         int'(Err),         int'(m_err));
    end

    task automatic wait_for(input int n, input int ph, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Fin);
            if (m_on && (m_n == n) && (m_ph == ph)) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: timed out waiting for N=%0d phase %0d", name, n, ph);
        end
    endtask

    task automatic xfer(input logic [7:0] v);
        Div_in    = v;
        Div_valid = 1'b1;
        @(negedge Fin);
        Div_valid = 1'b0;
    endtask

    task automatic capture(input int k, output logic [15:0] f, output logic [15:0] t,
                           output logic [15:0] a);
        f = '0; t = '0; a = '0;
        for (int i = 0; i < k; i++) begin
            f = {f[14:0], Fout};
            t = {t[14:0], Period_tick};
            a = {a[14:0], Active};
            @(negedge Fin);
        end
    endtask

    logic [15:0] cf, ct, ca;

    initial begin
        #1 Reset = 1'b1;
        @(negedge Fin);
        chk("reset_fout",  int'(Fout),      0);
        chk("reset_ready", int'(Div_ready), 1);
        chk("reset_act",   int'(Active),    0);
        @(negedge Fin);
        Reset = 1'b0;
        En    = 1'b1;
        @(negedge Fin);

        // Default N=2: pure toggle, tick every other cycle.
        capture(4, cf, ct, ca);
        chk("n2_fout", int'(cf), 'b1010);
        chk("n2_tick", int'(ct), 'b1010);
        chk("n2_act",  int'(ca), 'b1111);

        // N=5: 2 high / 3 low, ready low until the cycle after apply.
        xfer(8'd5);
        chk("ready_after_xfer", int'(Div_ready), 0);
        wait_for(5, 0, "apply5");
        capture(10, cf, ct, ca);
        chk("n5_fout", int'(cf), 'b1100011000);
        chk("n5_tick", int'(ct), 'b1000010000);
        chk("ready_after_apply", int'(Div_ready), 1);

        // Ratio 1 clamps to 2 and sets sticky Err.
        xfer(8'd1);
        chk("err_set", int'(Err), 1);
        wait_for(2, 0, "apply_clamp");

        // N=6, drop En at cnt=1: period completes then halts low.
        xfer(8'd6);
        wait_for(6, 1, "apply6");
        En = 1'b0;
        @(negedge Fin);
        capture(8, cf, ct, ca);
        chk("stop_fout", int'(cf), 'b10000000);
        chk("stop_tick", int'(ct), 'b00000000);
        chk("stop_act",  int'(ca), 'b11110000);

        // Re-raise En at cnt=4 while stopping: waveform unbroken.
        En = 1'b1;
        wait_for(6, 1, "restart6");
        En = 1'b0;
        @(negedge Fin);
        cf = '0; ca = '0;
        for (int i = 0; i < 8; i++) begin
            cf = {cf[14:0], Fout};
            ca = {ca[14:0], Active};
            if (i == 2) En = 1'b1;
            @(negedge Fin);
        end
        chk("resume_fout", int'(cf), 'b10001110);
        chk("resume_act",  int'(ca), 'b11111111);

        // Transfer during the wrap cycle of N=3: one more N=3 period, then N=4.
        xfer(8'd3);
        wait_for(3, 2, "apply3");
        Div_in    = 8'd4;
        Div_valid = 1'b1;
        @(negedge Fin);
        Div_valid = 1'b0;
        capture(7, cf, ct, ca);
        chk("wrap_xfer_fout", int'(cf), 'b1001100);
        chk("err_sticky", int'(Err), 1);

        // Reset mid-period with a pending ratio: immediate reset, pending dropped.
        wait_for(4, 1, "apply4");
        xfer(8'd7);
        #2 Reset = 1'b1;
        #1;
        chk("rst_fout",  int'(Fout),        0);
        chk("rst_tick",  int'(Period_tick), 0);
        chk("rst_ready", int'(Div_ready),   1);
        chk("rst_act",   int'(Active),      0);
        chk("rst_err",   int'(Err),         0);
        @(negedge Fin);
        Reset = 1'b0;
        @(negedge Fin);
        capture(6, cf, ct, ca);
        chk("post_rst_fout", int'(cf), 'b101010);

        En = 1'b0;
        repeat (10) @(negedge Fin);
        chk("final_act", int'(Active), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
